// File: rtl/audio_pkg.sv
// Shared constants and types for the stereo audio sample feeder.
// Optional underrun counter is enabled by AUDIO_FEEDER_UNDERRUN_EN.
package audio_pkg;

    // Default bits per channel; a packed stereo sample is twice this.
    localparam int AUDIO_BITS_DFLT = 12;

    // Default FIFO depth in samples (power of two, >= 2).
    localparam int DEPTH_DFLT = 16;

    // Width of the saturating underrun counter.
    localparam int UNDERRUN_W = 16;

    // Request sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } feed_state_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Single-clock sample FIFO with push, pop, synchronous flush and
// registered level/empty/full. Level is tracked apart from pointers.
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int W     = 2 * AUDIO_BITS_DFLT,
    parameter int DEPTH = DEPTH_DFLT,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk_audio,
    input  logic          aclr,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  logic [W-1:0]  i_data,
    output logic [W-1:0]  o_data,
    output logic [LW-1:0] o_level,
    output logic          o_empty,
    output logic          o_full
);

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [LW-1:0] LVL_ONE = LW'(1);
    localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          r_empty;
    logic          r_full;

    logic          w_push;
    logic          w_pop;
    logic [LW-1:0] w_level_nxt;

    assign w_push = i_push && !r_full && !i_flush;
    assign w_pop  = i_pop && !r_empty && !i_flush;

    // Next occupancy; simultaneous push and pop leaves it unchanged.
    always_comb begin
        w_level_nxt = r_level;
        if (i_flush) begin
            w_level_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_level_nxt = r_level + LVL_ONE;
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - LVL_ONE;
        end
    end

    // Pointer, level and flag registers; flush clears them synchronously.
    always_ff @(posedge clk_audio or posedge aclr) begin
        if (aclr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            if (i_flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + PTR_ONE;
                if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
            end
            r_level <= w_level_nxt;
            r_empty <= (w_level_nxt == '0);
            r_full  <= (w_level_nxt == LVL_MAX);
        end
    end

    // Sample storage; contents are don't-care until written.
    always_ff @(posedge clk_audio) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    assign o_data  = r_mem[r_rptr];
    assign o_level = r_level;
    assign o_empty = r_empty;
    assign o_full  = r_full;

endmodule

// File: rtl/audio_sample_feeder.sv
// Stereo PCM feeder: buffers producer samples and issues one wreq pulse
// per DAC ready window. Macro AUDIO_FEEDER_UNDERRUN_EN adds underrun_count.
module audio_sample_feeder
    import audio_pkg::*;
#(
    parameter int AUDIO_BITS = AUDIO_BITS_DFLT,
    parameter int DEPTH      = DEPTH_DFLT,
    localparam int SW        = 2 * AUDIO_BITS,
    localparam int LW        = $clog2(DEPTH) + 1
) (
    input  logic          clk_audio,
    input  logic          aclr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [SW-1:0] in_sample,
    input  logic          flush,
    input  logic          dac_ready,
    output logic          wreq,
    output logic [SW-1:0] sample,
    output logic [LW-1:0] level,
    output logic          empty,
    output logic          full
`ifdef AUDIO_FEEDER_UNDERRUN_EN
    ,
    output logic [UNDERRUN_W-1:0] underrun_count
`endif
);

    feed_state_t   r_state;
    feed_state_t   w_state_nxt;
    logic          w_pop;
    logic          w_push;
    logic          r_wreq;
    logic [SW-1:0] r_sample;
    logic [SW-1:0] w_head;
    logic          w_empty;
    logic          w_full;

    assign in_ready = !w_full && !flush;
    assign w_push   = in_valid && in_ready;

    audio_sample_fifo #(
        .W     (SW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_audio (clk_audio),
        .aclr      (aclr),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_flush   (flush),
        .i_data    (in_sample),
        .o_data    (w_head),
        .o_level   (level),
        .o_empty   (w_empty),
        .o_full    (w_full)
    );

    assign empty = w_empty;
    assign full  = w_full;

    // Sequencer next state; a pop happens only on IDLE -> REQ.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (dac_ready && !w_empty && !flush) begin
                    w_state_nxt = ST_REQ;
                    w_pop       = 1'b1;
                end
            end
            ST_REQ: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (!dac_ready) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register plus the wreq pulse and held output sample.
    always_ff @(posedge clk_audio or posedge aclr) begin
        if (aclr) begin
            r_state  <= ST_IDLE;
            r_wreq   <= 1'b0;
            r_sample <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wreq  <= w_pop;
            if (w_pop) r_sample <= w_head;
        end
    end

    assign wreq   = r_wreq;
    assign sample = r_sample;

`ifdef AUDIO_FEEDER_UNDERRUN_EN
    logic                  r_dac_ready_q;
    logic [UNDERRUN_W-1:0] r_underrun_count;
    logic                  w_dac_rise;

    assign w_dac_rise = dac_ready && !r_dac_ready_q;

    // Count ready rising edges that find the buffer empty; saturates.
    always_ff @(posedge clk_audio or posedge aclr) begin
        if (aclr) begin
            r_dac_ready_q    <= 1'b0;
            r_underrun_count <= '0;
        end else begin
            r_dac_ready_q <= dac_ready;
            if (w_dac_rise && w_empty && (r_underrun_count != '1)) begin
                r_underrun_count <= r_underrun_count + UNDERRUN_W'(1);
            end
        end
    end

    assign underrun_count = r_underrun_count;
`endif

endmodule

// File: tb/tb_audio_sample_feeder.sv
// Directed self-checking bench for audio_sample_feeder.
// Underrun checks are compiled when AUDIO_FEEDER_UNDERRUN_EN is defined.
module tb_audio_sample_feeder;

    localparam int SW = 24;
    localparam int LW = 5;

    logic          clk_audio = 1'b0;
    logic          aclr;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_sample;
    logic          flush;
    logic          dac_ready;
    logic          wreq;
    logic [SW-1:0] sample;
    logic [LW-1:0] level;
    logic          empty;
    logic          full;
`ifdef AUDIO_FEEDER_UNDERRUN_EN
    logic [15:0]   underrun_count;
`endif

    int total = 0;
    int bad   = 0;

    audio_sample_feeder #(
        .AUDIO_BITS (12),
        .DEPTH      (16)
    ) dut (
        .clk_audio (clk_audio),
        .aclr      (aclr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sample (in_sample),
        .flush     (flush),
        .dac_ready (dac_ready),
        .wreq      (wreq),
        .sample    (sample),
        .level     (level),
        .empty     (empty),
        .full      (full)
`ifdef AUDIO_FEEDER_UNDERRUN_EN
        ,
        .underrun_count (underrun_count)
`endif
    );

    always #5 clk_audio = ~clk_audio;

    task automatic tick();
        @(posedge clk_audio);
        #1;
    endtask

    task automatic push_n(input int n, input logic [SW-1:0] base);
        for (int i = 0; i < n; i++) begin
            in_valid  = 1'b1;
            in_sample = base + SW'(i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        aclr = 1'b1; in_valid = 0; in_sample = '0;
        flush = 0; dac_ready = 0;
        tick(); tick();
        total++; if (wreq !== 1'b0) begin bad++;
            $display("FAIL reset_wreq got=%b exp=0", wreq); end
        total++; if (sample !== 24'h0) begin bad++;
            $display("FAIL reset_sample got=%h exp=0", sample); end
        total++; if (level !== 5'd0) begin bad++;
            $display("FAIL reset_level got=%0d exp=0", level); end
        total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++;
            $display("FAIL reset_flags got=%b%b exp=10", empty, full); end
        total++; if (in_ready !== 1'b1) begin bad++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        flush = 1'b1; #1;
        total++; if (in_ready !== 1'b0) begin bad++;
            $display("FAIL reset_in_ready_flush got=%b exp=0", in_ready); end
        flush = 1'b0;
        aclr = 1'b0;
        tick();
    endtask

    task automatic test_single();
        dac_ready = 1'b1;
        in_valid = 1'b1; in_sample = 24'hABC123;
        tick();
        in_valid = 1'b0;
        total++; if (level !== 5'd1 || wreq !== 1'b0) begin bad++;
            $display("FAIL single_push got=lvl%0d/w%b exp=lvl1/w0", level, wreq); end
        tick();
        total++; if (wreq !== 1'b1) begin bad++;
            $display("FAIL single_wreq got=%b exp=1", wreq); end
        total++; if (sample !== 24'hABC123) begin bad++;
            $display("FAIL single_sample got=%h exp=abc123", sample); end
        total++; if (level !== 5'd0) begin bad++;
            $display("FAIL single_level got=%0d exp=0", level); end
        tick();
        total++; if (wreq !== 1'b0) begin bad++;
            $display("FAIL single_pulse_width got=%b exp=0", wreq); end
        dac_ready = 1'b0;
        tick();
    endtask

    task automatic test_fill_drain();
        int pulses;
        dac_ready = 1'b0;
        push_n(16, 24'h5A0000);
        total++; if (full !== 1'b1 || in_ready !== 1'b0) begin bad++;
            $display("FAIL fill_full got=f%b/r%b exp=f1/r0", full, in_ready); end
        total++; if (level !== 5'd16) begin bad++;
            $display("FAIL fill_level got=%0d exp=16", level); end
        in_valid = 1'b1; in_sample = 24'h999999;
        tick();
        in_valid = 1'b0;
        total++; if (level !== 5'd16) begin bad++;
            $display("FAIL fill_17th got=%0d exp=16", level); end
        pulses = 0;
        for (int k = 0; k < 16; k++) begin
            dac_ready = 1'b1;
            tick();
            if (wreq === 1'b1) pulses++;
            total++;
            if (sample !== 24'h5A0000 + SW'(k)) begin bad++;
                $display("FAIL drain_order_%0d got=%h exp=%h",
                         k, sample, 24'h5A0000 + SW'(k)); end
            tick();
            dac_ready = 1'b0;
            tick();
        end
        total++; if (pulses != 16) begin bad++;
            $display("FAIL drain_pulses got=%0d exp=16", pulses); end
        total++; if (empty !== 1'b1) begin bad++;
            $display("FAIL drain_empty got=%b exp=1", empty); end
    endtask

    task automatic test_hold();
        int extra;
        dac_ready = 1'b0;
        push_n(2, 24'h123400);
        dac_ready = 1'b1;
        tick();
        total++; if (wreq !== 1'b1 || sample !== 24'h123400) begin bad++;
            $display("FAIL hold_first got=w%b/%h exp=w1/123400", wreq, sample); end
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (wreq === 1'b1) extra++;
        end
        total++; if (extra != 0) begin bad++;
            $display("FAIL hold_no_second got=%0d exp=0", extra); end
        total++; if (level !== 5'd1) begin bad++;
            $display("FAIL hold_level got=%0d exp=1", level); end
        dac_ready = 1'b0;
        tick();
        dac_ready = 1'b1;
        tick();
        total++; if (wreq !== 1'b1 || sample !== 24'h123401) begin bad++;
            $display("FAIL hold_second got=w%b/%h exp=w1/123401", wreq, sample); end
        tick();
        dac_ready = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        int pulses;
        dac_ready = 1'b0;
        push_n(3, 24'h777000);
        total++; if (level !== 5'd3) begin bad++;
            $display("FAIL flush_pre_level got=%0d exp=3", level); end
        in_valid = 1'b1; in_sample = 24'hDEAD00; flush = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++;
            $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        tick();
        in_valid = 1'b0; flush = 1'b0;
        total++; if (level !== 5'd0 || empty !== 1'b1) begin bad++;
            $display("FAIL flush_level got=%0d/e%b exp=0/e1", level, empty); end
        pulses = 0;
        dac_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (wreq === 1'b1) pulses++;
        end
        total++; if (pulses != 0) begin bad++;
            $display("FAIL flush_no_wreq got=%0d exp=0", pulses); end
        dac_ready = 1'b0;
        tick();
    endtask

    task automatic test_aclr_wait();
        dac_ready = 1'b0;
        push_n(5, 24'h0C0C00);
        dac_ready = 1'b1;
        tick();
        tick();
        total++; if (level !== 5'd4 || sample !== 24'h0C0C00) begin bad++;
            $display("FAIL aclr_pre got=%0d/%h exp=4/0c0c00", level, sample); end
        #2;
        aclr = 1'b1;
        #1;
        total++; if (wreq !== 1'b0 || level !== 5'd0) begin bad++;
            $display("FAIL aclr_async got=w%b/%0d exp=w0/0", wreq, level); end
        total++; if (sample !== 24'h0) begin bad++;
            $display("FAIL aclr_sample got=%h exp=0", sample); end
        tick();
        aclr = 1'b0;
        in_valid = 1'b1; in_sample = 24'h0FACE0;
        tick();
        in_valid = 1'b0;
        tick();
        total++; if (wreq !== 1'b1 || sample !== 24'h0FACE0) begin bad++;
            $display("FAIL aclr_idle_after got=w%b/%h exp=w1/0face0", wreq, sample); end
        tick();
        dac_ready = 1'b0;
        tick();
    endtask

`ifdef AUDIO_FEEDER_UNDERRUN_EN
    task automatic test_underrun();
        dac_ready = 1'b0;
        aclr = 1'b1;
        tick();
        aclr = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            dac_ready = 1'b1;
            tick();
            dac_ready = 1'b0;
            tick();
        end
        total++; if (underrun_count !== 16'd3) begin bad++;
            $display("FAIL underrun_count got=%0d exp=3", underrun_count); end
        force dut.r_underrun_count = 16'hFFFF;
        tick();
        release dut.r_underrun_count;
        dac_ready = 1'b1;
        tick();
        dac_ready = 1'b0;
        tick();
        total++; if (underrun_count !== 16'hFFFF) begin bad++;
            $display("FAIL underrun_sat got=%h exp=ffff", underrun_count); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (underrun_count !== 16'hFFFF) begin bad++;
            $display("FAIL underrun_flush got=%h exp=ffff", underrun_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_hold();
        test_flush();
        test_aclr_wait();
`ifdef AUDIO_FEEDER_UNDERRUN_EN
        test_underrun();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
